// File: rtl/cam_pkg.sv
// Shared constants and capture-state encoding for the camera capture path.
// Also carries the RAM address/data widths reused by test_cam.
package cam_pkg;

  localparam int CAM_SCREEN_X = 160;
  localparam int CAM_SCREEN_Y = 120;
  localparam int AW           = 15;
  localparam int DW           = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2
  } cap_state_e;

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Control/status bundle between software/buttons, cam_read2_0 and the capture sequencer.
// Also exposes the sequencer state for debug visibility.
interface cam_capture_ctrl_if #(
  parameter int FCW = 8
);
  import cam_pkg::*;

  // start/stop are single-cycle requests with no ready: start is taken only in IDLE,
  // stop only in ARM/CAPT. px_valid is a single-cycle strobe that is never back-pressured.
  logic           start;
  logic           stop;
  logic           cont;
  logic           CAM_vsync;
  logic           CAM_href;
  logic           px_valid;
  logic           wr_en;
  logic           busy;
  logic           done;
  logic [FCW-1:0] frame_cnt;
  logic           size_err;
  cap_state_e     dbg_state;

  modport master (
    output start, stop, cont, CAM_vsync, CAM_href, px_valid,
    input  wr_en, busy, done, frame_cnt, size_err, dbg_state
  );

  modport slave (
    input  start, stop, cont, CAM_vsync, CAM_href, px_valid,
    output wr_en, busy, done, frame_cnt, size_err, dbg_state
  );

endinterface

// File: rtl/sync_edge_det.sv
// One-register edge detector; the register resets to 0 so a level already high
// at reset release reads as a rising edge, never as a falling one.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer gating DP-RAM writes to whole frames on request.
// Define CAM_SIZE_CHECK_EN to enable the per-line/per-frame geometry check.
module cam_capture_ctrl #(
  parameter int CAM_SCREEN_X = cam_pkg::CAM_SCREEN_X,
  parameter int CAM_SCREEN_Y = cam_pkg::CAM_SCREEN_Y,
  parameter int FCW          = 8
) (
  input  logic               clk,
  input  logic               rst,
  cam_capture_ctrl_if.slave  bus
);
  import cam_pkg::*;

  cap_state_e     r_state;
  cap_state_e     w_next;
  logic           r_busy;
  logic           r_cont;
  logic           r_stop_pend;
  logic [FCW-1:0] r_frame_cnt;
  logic           w_done;
  logic           w_vs_rise;
  logic           w_vs_fall;
  logic           w_hr_fall;
  logic           w_unused_hr_rise;
  logic           w_start_ok;
  logic           w_frame_end;

  sync_edge_det u_vs_det (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.CAM_vsync),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  sync_edge_det u_hr_det (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.CAM_href),
    .o_rise (w_unused_hr_rise),
    .o_fall (w_hr_fall)
  );

  assign w_start_ok  = (r_state == IDLE) && bus.start && !bus.stop;
  assign w_frame_end = (r_state == CAPT) && w_vs_rise;

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (bus.start && !bus.stop) w_next = ARM;
      ARM: begin
        if (bus.stop)       w_next = IDLE;
        else if (w_vs_fall) w_next = CAPT;
      end
      CAPT: begin
        // A stop never truncates a frame; it only prevents re-arming at frame end.
        if (w_vs_rise) begin
          if (r_cont && !r_stop_pend && !bus.stop) begin
            w_next = ARM;
          end else begin
            w_next = IDLE;
            w_done = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      if (w_start_ok) begin
        r_cont      <= bus.cont;
        r_stop_pend <= 1'b0;
      end else if ((r_state == CAPT) && bus.stop) begin
        r_stop_pend <= 1'b1;
      end
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

`ifdef CAM_SIZE_CHECK_EN
  localparam logic [8:0] PIX_EXP  = 9'(CAM_SCREEN_X);
  localparam logic [7:0] LINE_EXP = 8'(CAM_SCREEN_Y);

  logic [8:0] r_pix_cnt;
  logic [7:0] r_line_cnt;
  logic       r_size_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_size_err <= 1'b0;
    end else begin
      if (w_start_ok) r_size_err <= 1'b0;
      if ((r_state == ARM) && w_vs_fall) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
      end else if (r_state == CAPT) begin
        if (w_hr_fall) begin
          r_pix_cnt <= '0;
          if (r_line_cnt != '1)      r_line_cnt <= r_line_cnt + 1'b1;
          if (r_pix_cnt != PIX_EXP)  r_size_err <= 1'b1;
        end else if (bus.px_valid && (r_pix_cnt != '1)) begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
        if (w_vs_rise && (r_line_cnt != LINE_EXP)) r_size_err <= 1'b1;
      end
    end
  end

  assign bus.size_err = r_size_err;
`else
  logic w_unused_geom;
  assign w_unused_geom = w_hr_fall ^ (CAM_SCREEN_X == 0) ^ (CAM_SCREEN_Y == 0);
  assign bus.size_err  = 1'b0;
`endif

  assign bus.wr_en     = bus.px_valid && (r_state == CAPT);
  assign bus.busy      = r_busy;
  assign bus.done      = w_done;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.dbg_state = r_state;

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Frame-capture sequencer between cam_read2_0 and buffer_ram_dp.
- Gates the capture write enable so frames reach the DP RAM only when software or buttons request them.
- Modes: single-shot snapshot (freeze image on VGA) and continuous capture.
- Runs in the camera pixel-clock domain; tracks frame and line boundaries from CAM_vsync and CAM_href, counts frames, and flags malformed frame geometry.

Parameters:
- CAM_SCREEN_X, 160, expected pixels per line (QQVGA).
- CAM_SCREEN_Y, 120, expected lines per frame.
- FCW, 8, width of frame counter.

Ports:
- clk  in  1  camera pixel clock (CAM_pclk).
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin capture.
- stop  in  1  one-cycle request to end capture.
- cont  in  1  1 = continuous mode, 0 = single-shot; sampled on accepted start.
- CAM_vsync  in  1  camera VSYNC; high = vertical blanking.
- CAM_href  in  1  camera HREF; high = active line.
- px_valid  in  1  DP_RAM_regW from cam_read2_0; one pulse per completed RGB444 pixel.
- wr_en  out  1  gated write enable to buffer_ram_dp regwrite.
- busy  out  1  high in ARM or CAPT.
- done  out  1  one-cycle pulse when capture sequence ends normally.
- frame_cnt  out  FCW  frames fully captured since reset; wraps.
- size_err  out  1  sticky geometry error; cleared by rst or accepted start.

Behaviour:
- Reset: state IDLE, wr_en=0, busy=0, done=0, frame_cnt=0, size_err=0, counters=0, vsync_q=0, href_q=0, cont_r=0, stop_pend=0.
- Edge detect: vsync_q and href_q are registered copies.
  - vs_fall = !CAM_vsync & vsync_q (frame start).
  - vs_rise = CAM_vsync & !vsync_q (frame end).
  - hr_fall = !CAM_href & href_q (line end).
  - vsync_q resets to 0, so no false frame start after reset mid-frame.
- wr_en = px_valid & (state==CAPT); combinational, zero latency.
- States:
  - IDLE: start → ARM; latch cont_r=cont; clear size_err and stop_pend.
  - ARM: vs_fall → CAPT; clear line_cnt and pix_cnt. stop → IDLE, no done.
  - CAPT:
    - px_valid increments pix_cnt, saturating at 2^9-1.
    - hr_fall: line_cnt++ (saturating at 2^8-1); check pix_cnt; pix_cnt←0.
    - stop sets stop_pend; the frame always completes.
    - vs_rise: check line_cnt; frame_cnt++.
      - If cont_r & !stop_pend (and no stop this cycle) → ARM.
      - Otherwise → IDLE with done=1 for that cycle.
- busy is registered: it is 1 the cycle after the transition into ARM/CAPT and 0 the cycle after returning to IDLE.
- Simultaneous start and stop in IDLE: stop wins, stay IDLE.
- start in ARM or CAPT is ignored.
- cont changes are ignored after start is accepted.
- vs_fall and hr_fall in the same cycle are legal; both are processed.
- frame_cnt wraps from 2^FCW-1 to 0.
- rst asserted in any state: next cycle IDLE, wr_en=0, and all outputs return to reset values.

Optional Feature:
- Macro: CAM_SIZE_CHECK_EN.
- Defined:
  - At hr_fall in CAPT, pix_cnt!=CAM_SCREEN_X sets size_err.
  - At vs_rise in CAPT, line_cnt!=CAM_SCREEN_Y sets size_err.
  - size_err is sticky; frame_cnt still increments.
- Undefined: pix_cnt/line_cnt logic is omitted and size_err is tied 0.

Decomposition:
- Shared package cam_pkg:
  - CAM_SCREEN_X, CAM_SCREEN_Y.
  - Capture-state encoding: IDLE=2'd0, ARM=2'd1, CAPT=2'd2.
  - Widths AW=15, DW=12 for reuse in test_cam.
- Sub-module sync_edge_det: one register plus rise/fall outputs, instantiated for CAM_vsync and CAM_href.

Test Plan:
- Single-shot: rst, start with cont=0, then two 160x120 frames.
  - wr_en pulses for exactly 19200 px_valid of frame 1 only.
  - done pulses once at frame-1 vs_rise; frame_cnt=1; busy=0 after.
- Continuous with stop mid-frame: start cont=1, three frames, stop asserted at line 60 of frame 3.
  - Frame 3 completes; frame_cnt=3; done at frame-3 vs_rise.
  - No wr_en in frame 4.
- Stop in ARM: start, then stop before vs_fall.
  - Returns to IDLE; done=0; wr_en never asserted; frame_cnt=0.
- Geometry (CAM_SIZE_CHECK_EN defined): frame with one 159-pixel line.
  - size_err=1 after that line and stays 1.
  - Next start clears it; a correct 160x120 frame leaves size_err=0.
- Reset mid-capture: rst at line 40 of CAPT.
  - Next cycle wr_en=0, busy=0, frame_cnt=0.
  - Remaining lines of that frame produce no wr_en.
  - start afterwards waits for the next vs_fall.
- Corner cases: start and stop in the same cycle in IDLE → stays IDLE. With FCW=2, five frames captured → frame_cnt=1 (wrap).
